// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcode/funct encodings, FSM state enum and ALU control
// shared by the mips_mc core and its controller.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, IMMEX, IMMWB, JUMP, HALT
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  // An R-type funct outside this set stops the core.
  function automatic logic functKnown(input logic [5:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_op_t functToAluOp(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle FSM and control decode for mips_mc.
// Optional feature: define MIPS_MC_BNE_EN to decode bne through BRANCH;
// without it bne is an illegal opcode and halts the core.
module mips_mc_ctrl
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_memAck,
  input  logic       i_regsEqual,
  output logic       o_memReq,
  output logic       o_memWe,
  output logic       o_addrFromAlu,
  output logic       o_fetchDone,
  output logic       o_decodeLatch,
  output logic       o_aluLatch,
  output logic       o_aluSrcImm,
  output logic       o_immZeroExt,
  output logic [2:0] o_aluOp,
  output logic       o_mdrWrite,
  output logic       o_regWrite,
  output logic       o_regDstRd,
  output logic       o_wbFromMem,
  output logic       o_pcBranch,
  output logic       o_pcJump,
  output logic       o_halted
);

  state_t r_state;
  state_t w_stateNext;

  // State register; reset always restarts at FETCH, abandoning any access.
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_stateNext;
  end

  // Next-state selection and per-state control strobes.
  always_comb begin
    w_stateNext   = r_state;
    o_memReq      = 1'b0;
    o_memWe       = 1'b0;
    o_addrFromAlu = 1'b0;
    o_fetchDone   = 1'b0;
    o_decodeLatch = 1'b0;
    o_aluLatch    = 1'b0;
    o_aluSrcImm   = 1'b0;
    o_immZeroExt  = 1'b0;
    o_aluOp       = ALU_ADD;
    o_mdrWrite    = 1'b0;
    o_regWrite    = 1'b0;
    o_regDstRd    = 1'b0;
    o_wbFromMem   = 1'b0;
    o_pcBranch    = 1'b0;
    o_pcJump      = 1'b0;
    o_halted      = 1'b0;
    case (r_state)
      FETCH: begin
        o_memReq = 1'b1;
        if (i_memAck) begin
          o_fetchDone = 1'b1;
          w_stateNext = DECODE;
        end
      end
      DECODE: begin
        o_decodeLatch = 1'b1;
        case (i_opcode)
          OP_RTYPE:        w_stateNext = functKnown(i_funct) ? EXEC : HALT;
          OP_LW, OP_SW:    w_stateNext = MEMADR;
          OP_BEQ:          w_stateNext = BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:          w_stateNext = BRANCH;
`else
          OP_BNE:          w_stateNext = HALT;
`endif
          OP_ADDI, OP_ORI: w_stateNext = IMMEX;
          OP_J:            w_stateNext = JUMP;
          default:         w_stateNext = HALT;
        endcase
      end
      MEMADR: begin
        o_aluLatch  = 1'b1;
        o_aluSrcImm = 1'b1;
        w_stateNext = (i_opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        o_memReq      = 1'b1;
        o_addrFromAlu = 1'b1;
        if (i_memAck) begin
          o_mdrWrite  = 1'b1;
          w_stateNext = MEMWB;
        end
      end
      MEMWB: begin
        o_regWrite  = 1'b1;
        o_wbFromMem = 1'b1;
        w_stateNext = FETCH;
      end
      MEMWR: begin
        o_memReq      = 1'b1;
        o_memWe       = 1'b1;
        o_addrFromAlu = 1'b1;
        if (i_memAck) w_stateNext = FETCH;
      end
      EXEC: begin
        o_aluLatch  = 1'b1;
        o_aluOp     = functToAluOp(i_funct);
        w_stateNext = ALUWB;
      end
      ALUWB: begin
        o_regWrite  = 1'b1;
        o_regDstRd  = 1'b1;
        w_stateNext = FETCH;
      end
      BRANCH: begin
`ifdef MIPS_MC_BNE_EN
        o_pcBranch = (i_opcode == OP_BNE) ? !i_regsEqual : i_regsEqual;
`else
        o_pcBranch = i_regsEqual;
`endif
        w_stateNext = FETCH;
      end
      IMMEX: begin
        o_aluLatch  = 1'b1;
        o_aluSrcImm = 1'b1;
        if (i_opcode == OP_ORI) begin
          o_immZeroExt = 1'b1;
          o_aluOp      = ALU_OR;
        end
        w_stateNext = IMMWB;
      end
      IMMWB: begin
        o_regWrite  = 1'b1;
        w_stateNext = FETCH;
      end
      JUMP: begin
        o_pcJump    = 1'b1;
        w_stateNext = FETCH;
      end
      HALT:    o_halted = 1'b1;
      default: w_stateNext = HALT;
    endcase
  end

endmodule

// File: rtl/mips_mc.sv
// mips_mc: multicycle MIPS subset core with one shared memory port.
// Datapath, register file and ALU live here; sequencing is in mips_mc_ctrl.
// Optional feature: define MIPS_MC_BNE_EN to add the bne instruction.
module mips_mc
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        halted
);

  localparam int RW = $clog2(NREGS);

  logic [31:0] r_pc, r_instr, r_a, r_b, r_target, r_aluOut, r_mdr;
  logic [31:0] r_regs [NREGS];

  logic w_memReq, w_memWe, w_addrFromAlu, w_fetchDone, w_decodeLatch;
  logic w_aluLatch, w_aluSrcImm, w_immZeroExt, w_mdrWrite, w_regWrite;
  logic w_regDstRd, w_wbFromMem, w_pcBranch, w_pcJump, w_halted, w_regsEqual;
  logic [2:0]    w_aluOp;
  logic [RW-1:0] w_rsIdx, w_rtIdx, w_rdIdx, w_wbIdx;
  logic [31:0]   w_rsVal, w_rtVal, w_immSext, w_immZext, w_aluB, w_aluResult, w_wbData;

  mips_mc_ctrl u_ctrl (
    .clk           (clk),
    .reset         (reset),
    .i_opcode      (r_instr[31:26]),
    .i_funct       (r_instr[5:0]),
    .i_memAck      (mem_ack),
    .i_regsEqual   (w_regsEqual),
    .o_memReq      (w_memReq),
    .o_memWe       (w_memWe),
    .o_addrFromAlu (w_addrFromAlu),
    .o_fetchDone   (w_fetchDone),
    .o_decodeLatch (w_decodeLatch),
    .o_aluLatch    (w_aluLatch),
    .o_aluSrcImm   (w_aluSrcImm),
    .o_immZeroExt  (w_immZeroExt),
    .o_aluOp       (w_aluOp),
    .o_mdrWrite    (w_mdrWrite),
    .o_regWrite    (w_regWrite),
    .o_regDstRd    (w_regDstRd),
    .o_wbFromMem   (w_wbFromMem),
    .o_pcBranch    (w_pcBranch),
    .o_pcJump      (w_pcJump),
    .o_halted      (w_halted)
  );

  assign w_rsIdx     = r_instr[21 +: RW];
  assign w_rtIdx     = r_instr[16 +: RW];
  assign w_rdIdx     = r_instr[11 +: RW];
  assign w_rsVal     = (w_rsIdx == '0) ? '0 : r_regs[w_rsIdx];
  assign w_rtVal     = (w_rtIdx == '0) ? '0 : r_regs[w_rtIdx];
  assign w_immSext   = {{16{r_instr[15]}}, r_instr[15:0]};
  assign w_immZext   = {16'h0000, r_instr[15:0]};
  assign w_regsEqual = (r_a == r_b);
  assign w_wbIdx     = w_regDstRd ? w_rdIdx : w_rtIdx;
  assign w_wbData    = w_wbFromMem ? r_mdr : r_aluOut;

  // Outputs that must drop immediately while reset is held are gated here.
  assign mem_req   = w_memReq & ~reset;
  assign mem_we    = w_memWe & ~reset;
  assign halted    = w_halted & ~reset;
  assign mem_addr  = w_addrFromAlu ? r_aluOut : r_pc;
  assign mem_wdata = r_b;
  assign pc        = r_pc;

  // ALU: second operand is rt or the extended immediate; slt compares signed.
  always_comb begin
    w_aluB      = w_aluSrcImm ? (w_immZeroExt ? w_immZext : w_immSext) : r_b;
    w_aluResult = '0;
    case (alu_op_t'(w_aluOp))
      ALU_ADD: w_aluResult = r_a + w_aluB;
      ALU_SUB: w_aluResult = r_a - w_aluB;
      ALU_AND: w_aluResult = r_a & w_aluB;
      ALU_OR:  w_aluResult = r_a | w_aluB;
      ALU_SLT: w_aluResult = {31'b0, $signed(r_a) < $signed(w_aluB)};
      default: w_aluResult = '0;
    endcase
  end

  // Datapath registers: PC, instruction, operands, branch target, ALU and load data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_target <= '0;
      r_aluOut <= '0;
      r_mdr    <= '0;
    end else begin
      if (w_fetchDone) begin
        r_instr <= mem_rdata;
        r_pc    <= r_pc + 32'd4;
      end else if (w_pcBranch) begin
        r_pc <= r_target;
      end else if (w_pcJump) begin
        r_pc <= {r_pc[31:28], r_instr[25:0], 2'b00};
      end
      if (w_decodeLatch) begin
        r_a      <= w_rsVal;
        r_b      <= w_rtVal;
        r_target <= r_pc + {w_immSext[29:0], 2'b00};
      end
      if (w_aluLatch) r_aluOut <= w_aluResult;
      if (w_mdrWrite) r_mdr <= mem_rdata;
    end
  end

  // Register file; writes to register 0 are dropped so it always reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_regWrite && (w_wbIdx != '0)) begin
      r_regs[w_wbIdx] <= w_wbData;
    end
  end

endmodule

// File: doc/mips_mc.md
MIPS_MC -- requirements
Module: mips_mc

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, 8..32); register index = low log2(NREGS) bits of rs/rt/rd.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  unified instruction/data memory request.
REQ-006 SHALL have port mem_we  output  1  request is a write (valid with mem_req).
REQ-007 SHALL have port mem_addr  output  32  byte address, word-aligned.
REQ-008 SHALL have port mem_wdata  output  32  store data.
REQ-009 SHALL have port mem_rdata  input  32  read data, valid in ack cycle.
REQ-010 SHALL have port mem_ack  input  1  access completes in the cycle mem_req && mem_ack.
REQ-011 SHALL have port pc  output  32  current PC.
REQ-012 SHALL have port halted  output  1  core stopped on illegal opcode.

Function
REQ-013 SHALL be a multicycle core with one shared memory port; instructions: add, sub, and, or, slt, lw, sw, beq, addi, ori, j.
REQ-014 SHALL run FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP, HALT.
REQ-015 SHALL hold mem_req, mem_we, mem_addr, mem_wdata stable in FETCH/MEMRD/MEMWR until ack; each missing ack adds one wait cycle.
REQ-016 SHALL on FETCH ack latch instr and set pc <= pc+4; DECODE reads rs/rt and computes branch target pc+4+(signext(imm)<<2).
REQ-017 SHALL take, with zero wait states: R-type 4, lw 5, sw 4, addi/ori 4, beq 3, j 3 cycles.
REQ-018 SHALL sign-extend imm for addi/lw/sw/beq and zero-extend for ori.
REQ-019 SHALL write rd for R-type, rt for lw/addi/ori; writes to register 0 are discarded and register 0 always reads 0.
REQ-020 SHALL update pc in BRANCH to target only if rs==rt; in JUMP to {pc[31:28], instr[25:0], 2'b00}.
REQ-021 SHALL compute slt as signed compare; add/sub/addi wrap modulo 2^32, no overflow trap.
REQ-022 SHALL enter HALT on unknown opcode or unknown R-type funct, set halted=1, issue no further requests until reset.
REQ-023 SHALL drive mem_addr = pc in FETCH, ALU result in MEMRD/MEMWR; mem_wdata = rt value.

Reset
REQ-024 SHALL force while reset=1: mem_req=0, mem_we=0, halted=0; after edge: pc=RESET_PC, state FETCH, all registers 0.
REQ-025 SHALL abandon any in-flight access on reset (mem_req low in the reset cycle); no register or PC update from it.

Configuration
REQ-026 SHALL with macro MIPS_MC_BNE_EN defined decode bne (opcode 6'b000101) via BRANCH, taken if rs!=rt, 3 cycles.
REQ-027 SHALL without MIPS_MC_BNE_EN treat opcode 6'b000101 as illegal (REQ-022).

Structure
REQ-028 SHALL place opcode/funct constants, FSM state enum and ALU-control typedef in package mips_mc_pkg.
REQ-029 SHALL implement the FSM and control decode as sub-module mips_mc_ctrl; register file and ALU are inline in mips_mc.

Verification
REQ-030 SHALL check: reset, RESET_PC=32'h100, ack always 1 -> first request mem_addr=32'h100, mem_we=0, one cycle after reset drops.
REQ-031 SHALL check: addi $1,$0,-5; ori $2,$0,0xFFFF; slt $3,$1,$2 -> $1=32'hFFFF_FFFB, $2=32'h0000_FFFF, $3=1.
REQ-032 SHALL check: sw $2,8($0); lw $4,8($0) with 3 wait cycles per access -> write addr 8 data 32'hFFFF; $4=32'hFFFF; lw takes 5+6=11 cycles.
REQ-033 SHALL check: beq taken at pc=0x20 with imm=-2 -> next fetch 0x1C; not taken -> 0x24; j 0x40 -> fetch 0x100.
REQ-034 SHALL check: opcode 6'b111111 -> halted=1, mem_req=0 forever; reset asserted in MEMRD wait state -> clean restart at RESET_PC, target register unchanged.
REQ-035 SHALL check: bne $0,$1 (nonzero) taken with MIPS_MC_BNE_EN; halts without it.
